// File: rtl/flash_wb_arbiter.sv
// flash_wb_arbiter
// Two-master round-robin Wishbone arbiter for the byte-wide flash slave.
// Master 0 is the instruction fetch bus. Master 1 is the data bus.
// After each transaction there is a forced one-cycle TURN gap, so the
// slave's wait-state counter returns to zero before the next grant.
//
// Optional feature: define FLASH_ARB_TIMEOUT_EN to build the grant watchdog.
// The watchdog ends a transaction with an error pulse when the slave has not
// acked within TIMEOUT_CYCLES grant cycles.
module flash_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int TO_W           = 6
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // master 0 (instruction fetch)
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1 (data)
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // flash slave
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  // Reject a watchdog limit that the counter cannot reach.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_bad_timeout_cfg
    $error("flash_wb_arbiter: TIMEOUT_CYCLES must be in 1 .. 2**TO_W-1");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_gnt;
  logic       last_gnt_nxt;
  logic       m0_req;
  logic       m1_req;
  logic       in_grant;
  logic       gnt0;
  logic       gnt1;
  logic       wd_expire;

  assign m0_req   = m0_cyc_i & m0_stb_i;
  assign m1_req   = m1_cyc_i & m1_stb_i;
  assign in_grant = (state == ST_GNT0) || (state == ST_GNT1);

  // NOTE: the grant terms are masked with reset, so nothing reaches either
  // bus while reset is high, including the cycle in which reset first appears.
  assign gnt0 = (state == ST_GNT0) && !wb_rst_i;
  assign gnt1 = (state == ST_GNT1) && !wb_rst_i;

`ifdef FLASH_ARB_TIMEOUT_EN
  logic [TO_W-1:0] wd_cnt;

  // Watchdog: held at zero outside a grant, counts ack-less grant cycles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !in_grant) begin
      wd_cnt <= '0;
    end else if (!s_ack_i) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // A real ack in the expiry cycle takes precedence over the timeout.
  assign wd_expire = in_grant && !s_ack_i &&
                     (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expire = 1'b0;
`endif

  // Next-state and round-robin decision.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      ST_IDLE: begin
        // On a tie, the master that did not win last time gets the grant.
        if (m0_req && (!m1_req || last_gnt)) begin
          state_nxt    = ST_GNT0;
          last_gnt_nxt = 1'b0;
        end else if (m1_req) begin
          state_nxt    = ST_GNT1;
          last_gnt_nxt = 1'b1;
        end
      end
      ST_GNT0: begin
        if (s_ack_i || !m0_cyc_i || wd_expire) begin
          state_nxt = ST_TURN;
        end
      end
      ST_GNT1: begin
        if (s_ack_i || !m1_cyc_i || wd_expire) begin
          state_nxt = ST_TURN;
        end
      end
      default: state_nxt = ST_IDLE;  // TURN always lasts exactly one cycle
    endcase
  end

  // State and last-grant registers.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: registered state uses non-blocking assignments only.
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Slave-side mux: forward the granted master, drive zeros otherwise.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    if (gnt0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_stb_o = m0_stb_i;
      s_cyc_o = m0_cyc_i;
    end else if (gnt1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_stb_o = m1_stb_i;
      s_cyc_o = m1_cyc_i;
    end
  end

  // Master-side returns. Ack is a combinational pass-through for the granted
  // master only.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = gnt0 & s_ack_i;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m0_err_o = gnt0 & wd_expire;
  assign m1_err_o = gnt1 & wd_expire;

endmodule

// File: tb/tb_flash_wb_arbiter.sv
// tb_flash_wb_arbiter
// Directed bench for flash_wb_arbiter. The stimulus pushes each expected
// master response (ack/err flags plus read data) into a queue. A monitor on
// the falling edge pops that queue whenever any ack or err is visible.
// The watchdog section follows FLASH_ARB_TIMEOUT_EN.
module tb_flash_wb_arbiter;

  typedef struct packed {
    logic [3:0]  flags;  // {m0_ack, m1_ack, m0_err, m1_err}
    logic [31:0] dat;
  } resp_t;

  localparam logic [3:0] R_M0_ACK = 4'b1000;
  localparam logic [3:0] R_M1_ACK = 4'b0100;
  localparam logic [3:0] R_M0_ERR = 4'b0010;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;

  int    checks = 0;
  int    errors = 0;
  resp_t sb_q[$];

  flash_wb_arbiter dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_sel_i (m0_sel_i),
    .m0_we_i  (m0_we_i),
    .m0_stb_i (m0_stb_i),
    .m0_cyc_i (m0_cyc_i),
    .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_sel_i (m1_sel_i),
    .m1_we_i  (m1_we_i),
    .m1_stb_i (m1_stb_i),
    .m1_cyc_i (m1_cyc_i),
    .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_stb_o  (s_stb_o),
    .s_cyc_o  (s_cyc_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge, where inputs change.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait for the falling edge, where outputs are sampled.
  task automatic sample();
    @(negedge wb_clk_i);
  endtask

  task automatic clear_inputs();
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0;
    m0_stb_i = 1'b0; m0_cyc_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0;
    m1_stb_i = 1'b0; m1_cyc_i = 1'b0;
    s_dat_i  = '0; s_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    wb_rst_i = 1'b1;
    tick_n(2);
    wb_rst_i = 1'b0;
  endtask

  task automatic m0_request(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    m0_adr_i = adr; m0_we_i = we; m0_dat_i = dat; m0_sel_i = 4'hF;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
  endtask

  task automatic m1_request(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    m1_adr_i = adr; m1_we_i = we; m1_dat_i = dat; m1_sel_i = 4'b0001;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
  endtask

  // Monitor: every visible ack/err must match the oldest queued expectation.
  always @(negedge wb_clk_i) begin
    logic [3:0] act_flags;
    resp_t      e;
    act_flags = {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o};
    if (act_flags != 4'b0000) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected flags=%b want none at %0t", act_flags, $time);
      end else begin
        e = sb_q.pop_front();
        if (act_flags != e.flags) begin
          errors++;
          $display("FAIL resp_flags got=%b want=%b at %0t", act_flags, e.flags, $time);
        end else if ((e.flags[3] | e.flags[2]) && (m0_dat_o !== e.dat || m1_dat_o !== e.dat)) begin
          errors++;
          $display("FAIL resp_data got=%h/%h want=%h at %0t", m0_dat_o, m1_dat_o, e.dat, $time);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    wb_rst_i = 1'b1;

    // ---- reset state ----
    tick();
    sample();
    check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    check("rst_s_adr", s_adr_o, 32'd0);
    check("rst_acks", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'd0);
    tick();
    wb_rst_i = 1'b0;

    // ---- single m0 read, slave acks 26 cycles after s_cyc_o ----
    m0_request(32'h0000_0010, 1'b0, 32'h0);
    sample();
    check("t1_idle_cyc", 32'(s_cyc_o), 32'd0);
    tick();                                   // grant cycle 1
    sample();
    check("t1_gnt_cyc", 32'(s_cyc_o), 32'd1);
    check("t1_gnt_stb", 32'(s_stb_o), 32'd1);
    check("t1_gnt_adr", s_adr_o, 32'h0000_0010);
    tick_n(26);                               // grant cycle 27
    s_ack_i = 1'b1;
    s_dat_i = 32'hA5A5_1234;
    sb_q.push_back('{flags: R_M0_ACK, dat: 32'hA5A5_1234});
    sample();
    tick();                                   // TURN
    s_ack_i = 1'b0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    sample();
    check("t1_turn_cyc", 32'(s_cyc_o), 32'd0);
    check("t1_turn_adr", s_adr_o, 32'd0);

    // ---- simultaneous requests, round robin, m1 held during m0 grant ----
    do_reset();
    m0_request(32'h0000_0100, 1'b0, 32'h0);
    m1_request(32'h0000_0200, 1'b1, 32'hDEAD_BEEF);
    tick();                                   // m0 grant cycle 1
    sample();
    check("t2_first_is_m0_adr", s_adr_o, 32'h0000_0100);
    check("t2_first_we", 32'(s_we_o), 32'd0);
    tick();
    m0_adr_i = 32'h0000_0104;
    sample();
    check("t2_track_adr", s_adr_o, 32'h0000_0104);
    tick();
    m0_adr_i = 32'h0000_0108;
    sample();
    check("t2_track_adr2", s_adr_o, 32'h0000_0108);
    tick();                                   // ack cycle n
    s_ack_i = 1'b1;
    s_dat_i = 32'h1111_2222;
    sb_q.push_back('{flags: R_M0_ACK, dat: 32'h1111_2222});
    sample();
    tick();                                   // n+1 TURN
    s_ack_i = 1'b0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    sample();
    check("t2_turn_cyc", 32'(s_cyc_o), 32'd0);
    tick();                                   // n+2 IDLE
    sample();
    check("t2_idle_cyc", 32'(s_cyc_o), 32'd0);
    tick();                                   // n+3 m1 grant
    sample();
    check("t2_m1_cyc", 32'(s_cyc_o), 32'd1);
    check("t2_m1_adr", s_adr_o, 32'h0000_0200);
    check("t2_m1_we", 32'(s_we_o), 32'd1);
    check("t2_m1_wdat", s_dat_o, 32'hDEAD_BEEF);
    check("t2_m1_sel", 32'(s_sel_o), 32'h1);
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0;
    sb_q.push_back('{flags: R_M1_ACK, dat: 32'h0});
    sample();
    tick();                                   // TURN: both request again
    s_ack_i = 1'b0;
    m0_request(32'h0000_0300, 1'b0, 32'h0);
    m1_request(32'h0000_0400, 1'b0, 32'h0);
    tick();                                   // IDLE
    tick();                                   // third round grant
    sample();
    check("t2_third_is_m0", s_adr_o, 32'h0000_0300);
    s_ack_i = 1'b1;
    s_dat_i = 32'h3333_4444;
    sb_q.push_back('{flags: R_M0_ACK, dat: 32'h3333_4444});
    sample();
    tick();
    s_ack_i = 1'b0;

    // ---- m0 aborts in grant cycle 5, late ack ignored ----
    do_reset();
    m0_request(32'h0000_0500, 1'b0, 32'h0);
    tick();                                   // grant cycle 1
    tick_n(4);                                // grant cycle 5
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    sample();
    check("t4_abort_cyc", 32'(s_cyc_o), 32'd0);
    tick();                                   // TURN
    s_ack_i = 1'b1;
    s_dat_i = 32'hBAD0_BAD0;
    sample();
    check("t4_turn_no_ack", 32'(m0_ack_o), 32'd0);
    check("t4_turn_cyc", 32'(s_cyc_o), 32'd0);
    tick();                                   // IDLE
    sample();
    check("t4_idle_no_ack", 32'(m0_ack_o), 32'd0);
    check("t4_idle_cyc", 32'(s_cyc_o), 32'd0);
    s_ack_i = 1'b0;

`ifdef FLASH_ARB_TIMEOUT_EN
    // ---- watchdog expiry: err in grant cycle 40 ----
    do_reset();
    m0_request(32'h0000_0600, 1'b0, 32'h0);
    tick();                                   // grant cycle 1
    tick_n(38);                               // grant cycle 39
    sample();
    check("t5_c39_no_err", 32'(m0_err_o), 32'd0);
    tick();                                   // grant cycle 40
    sb_q.push_back('{flags: R_M0_ERR, dat: 32'h0});
    sample();
    tick();                                   // TURN
    sample();
    check("t5_turn_cyc", 32'(s_cyc_o), 32'd0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;

    // ---- ack in grant cycle 40 wins over expiry ----
    do_reset();
    m0_request(32'h0000_0700, 1'b0, 32'h0);
    tick();
    tick_n(39);                               // grant cycle 40
    s_ack_i = 1'b1;
    s_dat_i = 32'h5A5A_0001;
    sb_q.push_back('{flags: R_M0_ACK, dat: 32'h5A5A_0001});
    sample();
    check("t5_ack_err_zero", 32'(m0_err_o), 32'd0);
    tick();
    s_ack_i = 1'b0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    sample();
    check("t5b_turn_cyc", 32'(s_cyc_o), 32'd0);
`else
    // ---- no watchdog: a stalled grant persists ----
    do_reset();
    m0_request(32'h0000_0600, 1'b0, 32'h0);
    tick();
    tick_n(50);
    sample();
    check("t5_still_granted", 32'(s_cyc_o), 32'd1);
    check("t5_no_err", 32'(m0_err_o), 32'd0);
    s_ack_i = 1'b1;
    s_dat_i = 32'h5A5A_0001;
    sb_q.push_back('{flags: R_M0_ACK, dat: 32'h5A5A_0001});
    sample();
    tick();
    s_ack_i = 1'b0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
`endif

    // ---- reset during GNT1 cycle 10 ----
    do_reset();
    m1_request(32'h0000_0800, 1'b0, 32'h0);
    tick();                                   // m1 grant cycle 1
    sample();
    check("t6_gnt1_adr", s_adr_o, 32'h0000_0800);
    tick_n(9);                                // grant cycle 10
    wb_rst_i = 1'b1;
    tick();                                   // first cycle after reset edge
    wb_rst_i = 1'b0;
    m0_request(32'h0000_0900, 1'b0, 32'h0);
    sample();
    check("t6_post_rst_cyc", 32'(s_cyc_o), 32'd0);
    check("t6_post_rst_adr", s_adr_o, 32'd0);
    check("t6_post_rst_acks", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'd0);
    tick();                                   // both requested in IDLE
    sample();
    check("t6_m0_wins", s_adr_o, 32'h0000_0900);
    s_ack_i = 1'b1;
    s_dat_i = 32'h7777_8888;
    sb_q.push_back('{flags: R_M0_ACK, dat: 32'h7777_8888});
    sample();
    tick();
    clear_inputs();
    tick_n(3);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
